// File: rtl/mul_seq_unit.sv
// Iterative shift-add multiplier for the RV32 M-extension multiply ops.
// A sign/magnitude front end feeds an unsigned accumulate loop; the sign is reapplied on completion.
module mul_seq_unit #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned EARLY_OUT      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned ITER = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned K    = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [K-1:0]         cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 lo_sel_q, lo_sel_d;
    logic                 res_lo_sel_q, res_lo_sel_d;
    logic [2*WIDTH-1:0]   res_q, res_d;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   partial, acc_sum;
    logic [WIDTH-1:0]     mplier_sh;
    logic [K-1:0]         cnt_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            neg_q        <= 1'b0;
            lo_sel_q     <= 1'b0;
            res_lo_sel_q <= 1'b0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            neg_q        <= neg_d;
            lo_sel_q     <= lo_sel_d;
            res_lo_sel_q <= res_lo_sel_d;
            res_q        <= res_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        neg_d        = neg_q;
        lo_sel_d     = lo_sel_q;
        res_lo_sel_d = res_lo_sel_q;
        res_d        = res_q;

        sign_a = a_in[WIDTH-1] & ((op == 2'b01) | (op == 2'b10));
        sign_b = b_in[WIDTH-1] & (op == 2'b01);
        mag_a  = sign_a ? ('0 - a_in) : a_in;
        mag_b  = sign_b ? ('0 - b_in) : b_in;

        partial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
        acc_sum   = acc_q + partial;
        mplier_sh = mplier_q >> BITS_PER_CYCLE;
        cnt_dec   = cnt_q - K'(1);

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    cnt_d    = K'(ITER);
                    neg_d    = sign_a ^ sign_b;
                    lo_sel_d = (op == 2'b00);
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_sh;
                cnt_d    = cnt_dec;
                // Exit decision uses this cycle's updated values so the final add is included.
                if ((cnt_dec == '0) || ((EARLY_OUT != 0) && (mplier_sh == '0))) begin
                    state_d      = DONE;
                    res_d        = neg_q ? ('0 - acc_sum) : acc_sum;
                    res_lo_sel_d = lo_sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign res_hi = res_q[2*WIDTH-1:WIDTH];
    assign res_lo = res_q[WIDTH-1:0];
    // The select travels with the result so a newly accepted op does not re-steer held results.
    assign result = res_lo_sel_q ? res_lo : res_hi;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed and model-checked bench for mul_seq_unit across three parameter sets.
module tb_mul_seq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_r [3];
    logic [1:0]  op_r    [3];
    logic [31:0] a_r     [3];
    logic [31:0] b_r     [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic [31:0] hi_w    [3];
    logic [31:0] lo_w    [3];
    logic [31:0] res_w   [3];

    int ncmp  = 0;
    int nfail = 0;
    int busy_err = 0;

    always #5 clk = ~clk;

    mul_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(0)) u0 (
        .clk(clk), .reset(reset), .start(start_r[0]), .op(op_r[0]), .a_in(a_r[0]), .b_in(b_r[0]),
        .busy(busy_w[0]), .done(done_w[0]), .res_hi(hi_w[0]), .res_lo(lo_w[0]), .result(res_w[0]));
    mul_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1)) u1 (
        .clk(clk), .reset(reset), .start(start_r[1]), .op(op_r[1]), .a_in(a_r[1]), .b_in(b_r[1]),
        .busy(busy_w[1]), .done(done_w[1]), .res_hi(hi_w[1]), .res_lo(lo_w[1]), .result(res_w[1]));
    mul_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(4), .EARLY_OUT(0)) u2 (
        .clk(clk), .reset(reset), .start(start_r[2]), .op(op_r[2]), .a_in(a_r[2]), .b_in(b_r[2]),
        .busy(busy_w[2]), .done(done_w[2]), .res_hi(hi_w[2]), .res_lo(lo_w[2]), .result(res_w[2]));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat1;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] ea, eb, p;
        ea = ((op == 2'b01) || (op == 2'b10)) ? {{34{a[31]}}, a} : {34'b0, a};
        eb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
        p  = ea * eb;
        return p[63:0];
    endfunction

    function automatic int exp_lat(input int u, input logic [1:0] op, input logic [31:0] b);
        logic [31:0] mag;
        int bl;
        if (u == 0) return 33;
        if (u == 2) return 9;
        mag = ((op == 2'b01) && b[31]) ? (32'd0 - b) : b;
        bl = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
        if (bl == 0) bl = 1;
        return bl + 1;
    endfunction

    // Counts rising edges until done is seen; -1 if it never arrives.
    task automatic wait_done(input int u, output int n);
        n = -1;
        for (int i = 1; i <= 120; i++) begin
            @(posedge clk); #1;
            if (done_w[u]) begin
                n = i;
                chk($sformatf("u%0d_busy_at_done", u), 64'(busy_w[u]), 64'(0));
                break;
            end
            if (!busy_w[u]) busy_err++;
        end
    endtask

    task automatic run_op(input int u, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        int n;
        @(negedge clk);
        start_r[u] = 1'b1; op_r[u] = op; a_r[u] = a; b_r[u] = b;
        @(posedge clk); #1;
        start_r[u] = 1'b0;
        wait_done(u, n);
        lat = (n < 0) ? -1 : n + 1;
    endtask

    task automatic check_op(input string nm, input int u, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo, input int elat);
        int lat;
        run_op(u, op, a, b, lat);
        chk({nm, "_lat"}, 64'(lat), 64'(elat));
        chk({nm, "_hi"}, 64'(hi_w[u]), 64'(ehi));
        chk({nm, "_lo"}, 64'(lo_w[u]), 64'(elo));
        chk({nm, "_result"}, 64'(res_w[u]), 64'((op == 2'b00) ? elo : ehi));
    endtask

    vec_t vecs [12];

    initial begin
        int n, lat;
        logic [1:0]  bop [4];
        logic [31:0] ba  [4];
        logic [31:0] bb  [4];
        logic [63:0] p;

        vecs[0]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 2};
        vecs[2]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
        vecs[3]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[4]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFEB, 33};
        vecs[5]  = '{2'b11, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 4};
        vecs[6]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 2};
        vecs[7]  = '{2'b01, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 3};
        vecs[8]  = '{2'b10, 32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFC, 3};
        vecs[9]  = '{2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 18};
        vecs[10] = '{2'b01, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 33};
        vecs[11] = '{2'b10, 32'h80000000, 32'h80000000, 32'hC0000000, 32'h00000000, 33};

        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin
            start_r[u] = 1'b0; op_r[u] = 2'b00; a_r[u] = '0; b_r[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d_rst_busy", u), 64'(busy_w[u]), 64'(0));
            chk($sformatf("u%0d_rst_done", u), 64'(done_w[u]), 64'(0));
            chk($sformatf("u%0d_rst_hi", u), 64'(hi_w[u]), 64'(0));
            chk($sformatf("u%0d_rst_lo", u), 64'(lo_w[u]), 64'(0));
        end
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            for (int u = 0; u < 3; u++) begin
                check_op($sformatf("v%0d_u%0d", i, u), u, vecs[i].op, vecs[i].a, vecs[i].b,
                         vecs[i].hi, vecs[i].lo, (u == 0) ? 33 : ((u == 1) ? vecs[i].lat1 : 9));
            end
        end

        // Back-to-back: start held high, new operands presented in each DONE cycle.
        bop[0] = 2'b00; ba[0] = 32'h00000007; bb[0] = 32'hFFFFFFFD;
        bop[1] = 2'b01; ba[1] = 32'h80000000; bb[1] = 32'h80000000;
        bop[2] = 2'b11; ba[2] = 32'h00001234; bb[2] = 32'h00000000;
        bop[3] = 2'b10; ba[3] = 32'hFFFFFFFE; bb[3] = 32'h00000005;
        @(negedge clk);
        start_r[1] = 1'b1; op_r[1] = bop[0]; a_r[1] = ba[0]; b_r[1] = bb[0];
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            wait_done(1, n);
            lat = (n < 0) ? -1 : ((k == 0) ? n + 1 : n);
            p = model(bop[k], ba[k], bb[k]);
            chk($sformatf("b2b%0d_lat", k), 64'(lat), 64'(exp_lat(1, bop[k], bb[k])));
            chk($sformatf("b2b%0d_prod", k), {hi_w[1], lo_w[1]}, p);
            if (k < 3) begin
                op_r[1] = bop[k+1]; a_r[1] = ba[k+1]; b_r[1] = bb[k+1];
            end else begin
                start_r[1] = 1'b0;
            end
        end

        // Start pulses and operand changes during RUN must not disturb the op in flight.
        @(negedge clk);
        start_r[0] = 1'b1; op_r[0] = 2'b11; a_r[0] = 32'd5; b_r[0] = 32'd9;
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        fork
            wait_done(0, n);
            begin
                repeat (5) @(negedge clk);
                start_r[0] = 1'b1; op_r[0] = 2'b01; a_r[0] = 32'hFFFFFFFF; b_r[0] = 32'h00012345;
                repeat (3) @(negedge clk);
                start_r[0] = 1'b0;
            end
        join
        chk("ign_lat", 64'((n < 0) ? -1 : n + 1), 64'(33));
        chk("ign_hi", 64'(hi_w[0]), 64'(0));
        chk("ign_lo", 64'(lo_w[0]), 64'h2D);
        chk("ign_result", 64'(res_w[0]), 64'(0));
        @(posedge clk); #1;
        chk("ign_done_after", 64'(done_w[0]), 64'(0));
        chk("ign_busy_after", 64'(busy_w[0]), 64'(0));

        // Reset mid-RUN: abort, clear, no stray done, then a clean op.
        check_op("pre_rst", 0, 2'b11, 32'h00001234, 32'h00000010, 32'h0, 32'h00012340, 33);
        @(negedge clk);
        start_r[0] = 1'b1; op_r[0] = 2'b11; a_r[0] = 32'hFFFFFFFF; b_r[0] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start_r[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", 64'(busy_w[0]), 64'(0));
        chk("mid_rst_done", 64'(done_w[0]), 64'(0));
        chk("mid_rst_hi", 64'(hi_w[0]), 64'(0));
        chk("mid_rst_lo", 64'(lo_w[0]), 64'(0));
        @(negedge clk); reset = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_w[0] || busy_w[0]) n++;
        end
        chk("mid_rst_stray", 64'(n), 64'(0));
        check_op("post_rst", 0, 2'b01, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);

        // Model-checked sweep with varied multiplier lengths and corner operands.
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < ((u == 2) ? 300 : 150); i++) begin
                logic [1:0]  rop;
                logic [31:0] ra, rb;
                rop = 2'($urandom_range(0, 3));
                ra  = $urandom;
                rb  = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
                if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'hFFFFFFFF;
                p = model(rop, ra, rb);
                check_op($sformatf("rnd%0d_u%0d", i, u), u, rop, ra, rb, p[63:32], p[31:0], exp_lat(u, rop, rb));
            end
        end

        chk("busy_in_run", 64'(busy_err), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
